mem_stage_unit: RTL and testbench

- Memory (M) stage data-memory access unit of the pipelined ARM core.
- Sits between the Execute-to-Memory register and the Memory-to-Writeback register, and produces ReadDataM for the writeback side.
- Models a word-addressed data RAM with a configurable number of wait states.
- Asserts StallM so the hazard logic freezes the upstream stages and holds the M-stage instruction until the access completes.

---
 rtl/mem_stage_unit.sv | 125 ++++++++++++
 tb/tb_mem_stage_unit.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_unit.sv
// M-stage data-memory access unit: word-addressed data RAM with a configurable
// number of wait states, raising StallM while an access is in flight.
module mem_stage_unit #(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWriteM,
  input  logic        MemtoRegM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        MemBusyM
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] w_index;
  logic          w_req;
  logic          w_unused_addr;

  // Byte offset and bits above the RAM size are dropped: aligned, wrapping index.
  assign w_index       = ALUOutM[AW+1:2];
  assign w_req         = MemWriteM | MemtoRegM;
  assign w_unused_addr = ^{ALUOutM[31:AW+2], ALUOutM[1:0]};

  logic [31:0] r_mem [DEPTH];

  if (WAIT_CYCLES == 0) begin : g_single_cycle
    logic w_unused_ctl;

    assign w_unused_ctl = reset ^ MemtoRegM;

    always_ff @(posedge clk) begin
      if (MemWriteM) begin
        r_mem[w_index] <= WriteDataM;
      end
    end

    assign ReadDataM = r_mem[w_index];
    assign StallM    = 1'b0;
    assign MemBusyM  = 1'b0;

  end else begin : g_wait_states
    typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_LAST = 2'd2
    } state_t;

    // State and wait counter kept together so checkers can bind to one signal.
    typedef struct packed {
      state_t     state;
      logic [3:0] cnt;
    } fsm_t;

    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES >= 2) ? 4'(WAIT_CYCLES - 2) : 4'd0;

    fsm_t          r_fsm;
    logic [AW-1:0] r_addr_q;
    logic [31:0]   r_data_q;
    logic          r_wr_q;
    logic          r_busy;
    logic          w_unused_rd;

    assign w_unused_rd = MemtoRegM;

    always_ff @(posedge clk) begin
      if (reset) begin
        r_fsm.state <= S_IDLE;
        r_fsm.cnt   <= 4'd0;
        r_addr_q    <= '0;
        r_data_q    <= '0;
        r_wr_q      <= 1'b0;
        r_busy      <= 1'b0;
      end else begin
        case (r_fsm.state)
          S_IDLE: begin
            if (w_req) begin
              r_addr_q <= w_index;
              r_data_q <= WriteDataM;
              r_wr_q   <= MemWriteM;
              r_busy   <= 1'b1;
              if (WAIT_CYCLES == 1) begin
                r_fsm.state <= S_LAST;
              end else begin
                r_fsm.state <= S_WAIT;
                r_fsm.cnt   <= CNT_INIT;
              end
            end
          end
          S_WAIT: begin
            if (r_fsm.cnt == 4'd0) begin
              r_fsm.state <= S_LAST;
            end else begin
              r_fsm.cnt <= r_fsm.cnt - 4'd1;
            end
          end
          S_LAST: begin
            r_fsm.state <= S_IDLE;
            r_busy      <= 1'b0;
          end
          default: begin
            r_fsm.state <= S_IDLE;
            r_busy      <= 1'b0;
          end
        endcase
      end
    end

    // A reset landing in LAST abandons the access, so the store is gated off too.
    always_ff @(posedge clk) begin
      if (!reset && r_fsm.state == S_LAST && r_wr_q) begin
        r_mem[r_addr_q] <= r_data_q;
      end
    end

    assign StallM    = (r_fsm.state == S_WAIT) || (r_fsm.state == S_IDLE && w_req);
    assign ReadDataM = (r_fsm.state == S_LAST) ? r_mem[r_addr_q] : r_mem[w_index];
    assign MemBusyM  = r_busy;
  end

endmodule

// File: tb/tb_mem_stage_unit.sv
// Bench for mem_stage_unit: four instances with WAIT_CYCLES 0..3, each checked
// against a flat word-array memory model and the N-stall / 1-completion timing.
module tb_mem_stage_unit;

  localparam int DEPTH = 64;
  localparam int NI    = 4;

  logic        clk;
  logic        rst   [NI];
  logic        mw    [NI];
  logic        mr    [NI];
  logic [31:0] addr  [NI];
  logic [31:0] wd    [NI];
  logic [31:0] rdata [NI];
  logic        stall [NI];
  logic        busy  [NI];

  logic [31:0] model_mem [NI][DEPTH];

  int n_tests;
  int n_fail;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    mem_stage_unit #(.DEPTH(DEPTH), .WAIT_CYCLES(g)) u_dut (
      .clk       (clk),
      .reset     (rst[g]),
      .MemWriteM (mw[g]),
      .MemtoRegM (mr[g]),
      .ALUOutM   (addr[g]),
      .WriteDataM(wd[g]),
      .ReadDataM (rdata[g]),
      .StallM    (stall[g]),
      .MemBusyM  (busy[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One access on instance k (k wait states). Expected timing: k stall cycles,
  // then a completion cycle; MemBusyM high in every cycle after the first.
  task automatic access(input int k, input bit wr, input bit rd,
                        input logic [31:0] a, input logic [31:0] d,
                        input bit scramble, input logic [31:0] s_addr,
                        input logic [31:0] s_data,
                        input bit use_exp, input logic [31:0] exp_val);
    int unsigned idx;
    logic        exp_stall;
    logic        exp_busy;
    logic [31:0] exp_rd;
    idx     = (a >> 2) % DEPTH;
    mw[k]   = wr;
    mr[k]   = rd;
    addr[k] = a;
    wd[k]   = d;
    for (int c = 0; c <= k; c++) begin
      @(negedge clk);
      exp_stall = (c < k);
      exp_busy  = (c > 0);
      n_tests++;
      if (stall[k] !== exp_stall || busy[k] !== exp_busy) begin
        n_fail++;
        $display("FAIL timing w%0d addr=%h cyc%0d: got stall=%b busy=%b, want stall=%b busy=%b",
                 k, a, c, stall[k], busy[k], exp_stall, exp_busy);
      end
      if (c == k && rd && !wr) begin
        exp_rd = use_exp ? exp_val : model_mem[k][idx];
        n_tests++;
        if (rdata[k] !== exp_rd) begin
          n_fail++;
          $display("FAIL load_data w%0d addr=%h: got %h, want %h", k, a, rdata[k], exp_rd);
        end
      end
      step();
      if (scramble && c < k) begin
        mw[k]   = ($urandom_range(0, 1) == 1);
        mr[k]   = ($urandom_range(0, 1) == 1);
        addr[k] = s_addr;
        wd[k]   = s_data;
      end
    end
    if (wr) model_mem[k][idx] = d;
    mw[k] = 1'b0;
    mr[k] = 1'b0;
  endtask

  task automatic test_reset();
    for (int k = 0; k < NI; k++) begin
      rst[k] = 1'b1; mw[k] = 1'b0; mr[k] = 1'b0; addr[k] = '0; wd[k] = '0;
    end
    step(); step();
    for (int k = 0; k < NI; k++) rst[k] = 1'b0;
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      n_tests++;
      if (stall[k] !== 1'b0 || busy[k] !== 1'b0 || rdata[k] !== 32'h0) begin
        n_fail++;
        $display("FAIL reset w%0d: got stall=%b busy=%b rdata=%h, want 0 0 00000000",
                 k, stall[k], busy[k], rdata[k]);
      end
    end
    step();
  endtask

  task automatic test_store_load_w2();
    access(2, 1, 0, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    access(2, 0, 1, 32'h10, 32'h0, 0, 0, 0, 1, 32'hDEADBEEF);
  endtask

  task automatic test_single_cycle_w0();
    access(0, 1, 0, 32'h04, 32'h12345678, 0, 0, 0, 0, 0);
    access(0, 0, 1, 32'h04, 32'h0, 0, 0, 0, 1, 32'h12345678);
  endtask

  task automatic test_misaligned_wrap();
    access(2, 1, 0, 32'h103, 32'hA5A5A5A5, 0, 0, 0, 0, 0);
    access(2, 0, 1, 32'h000, 32'h0, 0, 0, 0, 1, 32'hA5A5A5A5);
    access(0, 1, 0, 32'h103, 32'hA5A5A5A5, 0, 0, 0, 0, 0);
    access(0, 0, 1, 32'h000, 32'h0, 0, 0, 0, 1, 32'hA5A5A5A5);
  endtask

  task automatic test_input_change_w3();
    access(3, 1, 0, 32'h20, 32'h1111, 1, 32'h40, 32'h2222, 0, 0);
    access(3, 0, 1, 32'h20, 32'h0, 0, 0, 0, 1, 32'h1111);
    access(3, 0, 1, 32'h40, 32'h0, 0, 0, 0, 1, 32'h0);
  endtask

  task automatic test_reset_mid_access_w3();
    mw[3] = 1'b1; addr[3] = 32'h08; wd[3] = 32'h55;
    step();
    mw[3]  = 1'b0;
    rst[3] = 1'b1;
    step();
    rst[3] = 1'b0;
    @(negedge clk);
    n_tests++;
    if (stall[3] !== 1'b0 || busy[3] !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid w3: got stall=%b busy=%b, want 0 0", stall[3], busy[3]);
    end
    step();
    access(3, 0, 1, 32'h08, 32'h0, 0, 0, 0, 1, 32'h0);
  endtask

  task automatic test_both_high_w1();
    access(1, 1, 1, 32'h0C, 32'h77, 0, 0, 0, 0, 0);
    access(1, 0, 1, 32'h0C, 32'h0, 0, 0, 0, 1, 32'h77);
  endtask

  task automatic test_back_to_back();
    int          op;
    logic [31:0] a;
    for (int k = 0; k < NI; k++) begin
      for (int n = 0; n < 60; n++) begin
        op = $urandom_range(0, 4);
        a  = ($urandom & 32'hFFFF_FF00) | (32'($urandom_range(0, 15)) << 2)
             | 32'($urandom_range(0, 3));
        if (op == 0) begin
          @(negedge clk);
          n_tests++;
          if (stall[k] !== 1'b0 || busy[k] !== 1'b0) begin
            n_fail++;
            $display("FAIL idle w%0d: got stall=%b busy=%b, want 0 0", k, stall[k], busy[k]);
          end
          step();
        end else begin
          access(k, (op == 1 || op == 2 || op == 4), (op == 3 || op == 4), a, $urandom,
                 1, $urandom, $urandom, 0, 0);
        end
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    for (int k = 0; k < NI; k++)
      for (int i = 0; i < DEPTH; i++) model_mem[k][i] = 32'h0;
    test_reset();
    test_store_load_w2();
    test_single_cycle_w0();
    test_misaligned_wrap();
    test_input_change_w3();
    test_reset_mid_access_w3();
    test_both_high_w1();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
